md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. Executes mult/multu/div/divu and mthi/mtlo, and holds the HI/LO registers that mfhi/mflo read. Latencies are parametrised. It drives a registered busy flag; hazard logic in D uses it to stall any md-class instruction while an operation is in flight.

---
 rtl/md_unit_pkg.sv | 26 ++
 rtl/md_calc.sv | 76 +++++++
 rtl/md_unit.sv | 106 ++++++++++
 tb/tb_md_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared operation codes, state encoding and sizing helper for the multiply/divide unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Counter must hold N-1 for the longer latency; never narrower than one bit.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int longest;
        longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return ($clog2(longest) > 0) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational product/quotient/remainder for mult/multu/div/divu, including the
// divide-by-zero and signed-overflow corner cases.
module md_calc
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0]      prod_sx;
    logic [2*WIDTH-1:0]      prod_u;
    logic                    div_zero;
    logic                    div_ovf;
    logic [WIDTH-1:0]        b_div_s;
    logic [WIDTH-1:0]        b_div_u;
    logic signed [WIDTH-1:0] quot_s;
    logic signed [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0]        quot_u;
    logic [WIDTH-1:0]        rem_u;

    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign prod_sx = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);

    // Divisors are steered away from the trapping cases; those results are overridden below.
    assign b_div_s = (div_zero || div_ovf) ? ONE : b;
    assign b_div_u = div_zero ? ONE : b;

    assign quot_s = $signed(a) / $signed(b_div_s);
    assign rem_s  = $signed(a) % $signed(b_div_s);
    assign quot_u = a / b_div_u;
    assign rem_u  = a % b_div_u;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md_op_e'(op))
            MDU_MULT:  {res_hi, res_lo} = prod_sx;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (div_zero) begin
                    res_lo = '1;
                    res_hi = a;
                end else if (div_ovf) begin
                    res_lo = MOST_NEG;
                    res_hi = '0;
                end else begin
                    res_lo = quot_s;
                    res_hi = rem_s;
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    res_lo = '1;
                    res_hi = a;
                end else begin
                    res_lo = quot_u;
                    res_hi = rem_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: holds HI/LO, computes results at acceptance and
// commits them after a fixed latency while signalling busy.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int               CNT_W     = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] temp_hi_reg, temp_hi_next;
    logic [WIDTH-1:0] temp_lo_reg, temp_lo_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] calc_hi, calc_lo;

    md_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .op    (op),
        .a     (A),
        .b     (B),
        .res_hi(calc_hi),
        .res_lo(calc_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            temp_hi_reg <= '0;
            temp_lo_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            temp_hi_reg <= temp_hi_next;
            temp_lo_reg <= temp_lo_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    // Priority: abort, then the in-flight countdown/commit, then a new request.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        temp_hi_next = temp_hi_reg;
        temp_lo_next = temp_lo_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        if (abort) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (state_reg == ST_BUSY) begin
            if (cnt_reg == '0) begin
                hi_next    = temp_hi_reg;
                lo_next    = temp_lo_reg;
                state_next = ST_IDLE;
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end else if (start) begin
            case (md_op_e'(op))
                MDU_MULT, MDU_MULTU: begin
                    temp_hi_next = calc_hi;
                    temp_lo_next = calc_lo;
                    cnt_next     = MULT_LOAD;
                    state_next   = ST_BUSY;
                end
                MDU_DIV, MDU_DIVU: begin
                    temp_hi_next = calc_hi;
                    temp_lo_next = calc_lo;
                    cnt_next     = DIV_LOAD;
                    state_next   = ST_BUSY;
                end
                MDU_MTHI: hi_next = A;
                MDU_MTLO: lo_next = A;
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == ST_BUSY);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random operations
// compared against an arithmetic reference model, on default and single-cycle latencies.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset_n;
    logic        start, abort;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    logic        start2, abort2;
    logic [2:0]  op2;
    logic [31:0] A2, B2;
    logic        busy2;
    logic [31:0] HI2, LO2;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi, m_lo, m2_hi, m2_lo;

    md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
        .abort(abort), .busy(busy), .HI(HI), .LO(LO)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op(op2), .A(A2), .B(B2),
        .abort(abort2), .busy(busy2), .HI(HI2), .LO(LO2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results from signed/unsigned arithmetic on magnitudes, not the RTL structure.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa, sb, ma, mb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    if (o == 3'd4) begin
                        sa = longint'({32'h0, a});
                        sb = longint'({32'h0, b});
                    end
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (sel) begin
            start2 = 1'b1; op2 = o; A2 = a; B2 = b;
        end else begin
            start = 1'b1; op = o; A = a; B = b;
        end
        @(posedge clk);
        #1;
        start = 1'b0; start2 = 1'b0; op = 3'd0; op2 = 3'd0;
    endtask

    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int          n, exp_n;
        logic [31:0] eh, el;
        issue(sel, o, a, b);
        eh = sel ? m2_hi : m_hi;
        el = sel ? m2_lo : m_lo;
        model(o, a, b, eh, el);
        if (o >= 3'd1 && o <= 3'd4) exp_n = sel ? 1 : ((o <= 3'd2) ? MC : DC);
        else exp_n = 0;
        n = 0;
        while ((sel ? busy2 : busy) && n < 64) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
        chk({tag, " HI"}, sel ? HI2 : HI, eh);
        chk({tag, " LO"}, sel ? LO2 : LO, el);
        if (sel) begin m2_hi = eh; m2_lo = el; end
        else begin m_hi = eh; m_lo = el; end
        $display("txn %s dut%0d op=%0d A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d",
                 tag, sel ? 1 : 0, o, a, b, sel ? HI2 : HI, sel ? LO2 : LO, n);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0; A = '0; B = '0;
        start2 = 1'b0; abort2 = 1'b0; op2 = 3'd0; A2 = '0; B2 = '0;
        m_hi = '0; m_lo = '0; m2_hi = '0; m2_lo = '0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset HI", HI, 32'h0);
        chk("reset LO", LO, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(0, 3'd1, 32'hFFFF_FFFF, 32'h2, "mult");
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'h2, "multu");
        run_op(0, 3'd3, 32'hFFFF_FFF9, 32'h2, "div_neg");
        run_op(0, 3'd4, 32'h7, 32'h2, "divu");
        run_op(0, 3'd3, 32'h1234_5678, 32'h0, "div_by_zero");
        run_op(0, 3'd4, 32'h8000_0000, 32'h0, "divu_by_zero");
        run_op(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        run_op(0, 3'd5, 32'hDEAD_BEEF, 32'h0, "mthi");
        run_op(0, 3'd6, 32'h1, 32'h0, "mtlo");
        run_op(0, 3'd0, 32'h5555_5555, 32'h0, "none");

        // In-flight op: a second request is ignored, then abort drops it without a commit.
        issue(0, 3'd1, 32'h3, 32'h4);
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'd100; B = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
        chk("busy_during_ignored_start", busy, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort busy", busy, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort HI kept", HI, m_hi);
        chk("abort LO kept", LO, m_lo);
        $display("txn abort: busy=%b HI=%h LO=%h", busy, HI, LO);

        // Abort wins over a simultaneous request while idle.
        @(negedge clk);
        abort = 1'b1; start = 1'b1; op = 3'd5; A = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0; op = 3'd0;
        chk("abort_vs_mthi HI", HI, m_hi);
        chk("abort_vs_mthi busy", busy, 1'b0);
        $display("txn abort_vs_mthi: HI=%h", HI);

        run_op(0, 3'd1, 32'h3, 32'h4, "mult_after_abort");

        for (int i = 0; i < 30; i++) begin
            r_op = 3'($urandom_range(1, 6));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'h0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 9));
                3: r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                default: ;
            endcase
            run_op(0, r_op, r_a, r_b, $sformatf("rand%0d", i));
        end

        run_op(1, 3'd1, 32'hFFFF_FFFF, 32'h2, "n1_mult");
        run_op(1, 3'd3, 32'hFFFF_FFF9, 32'h2, "n1_div");
        run_op(1, 3'd6, 32'hABCD_0123, 32'h0, "n1_mtlo");

        // Asynchronous reset in the middle of a divide.
        run_op(0, 3'd5, 32'h1357_9BDF, 32'h0, "mthi_pre_reset");
        issue(0, 3'd3, 32'd1000, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset busy", busy, 1'b0);
        chk("async_reset HI", HI, 32'h0);
        chk("async_reset LO", LO, 32'h0);
        chk("async_reset n1 LO", LO2, 32'h0);
        m_hi = '0; m_lo = '0; m2_hi = '0; m2_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset busy", busy, 1'b0);
        chk("post_reset HI", HI, 32'h0);
        chk("post_reset LO", LO, 32'h0);
        $display("txn async_reset: busy=%b HI=%h LO=%h", busy, HI, LO);

        run_op(0, 3'd2, 32'h0001_0000, 32'h0001_0000, "multu_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
